// File: rtl/snapshot_uart_tx_pkg.sv
// Shared definitions for the snapshot UART transmitter: byte FSM states,
// channel tags, default header and frame geometry.
package snapshot_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [2:0] TAG_100        = 3'b100;
    localparam logic [2:0] TAG_010        = 3'b010;
    localparam logic [2:0] TAG_001        = 3'b001;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES    = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(FRAME_BYTES - 1);

    function automatic logic [7:0] tag_byte(input logic [2:0] tag, input logic [4:0] val);
        return {tag, val};
    endfunction

endpackage

// File: rtl/snapshot_uart_tx_byte.sv
// One 8N1 byte transmitter with a pDIV-cycle bit timer. A load accepted on the
// final stop-bit cycle chains straight into the next start bit with no idle gap.
module uart_byte_tx
    import snapshot_uart_tx_pkg::*;
#(
    parameter int pDIV = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_timer;
    logic [15:0] w_timer_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_bit_end;

    assign w_bit_end = (r_timer == 16'(pDIV - 1));
    assign o_done    = (r_state == ST_STOP) && w_bit_end;
    assign o_tx      = r_tx;

    // Next-state, timer, shift and line-level computation.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = w_bit_end ? 16'd0 : (r_timer + 16'd1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = 16'd0;
                if (i_load) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = i_data;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = 3'd0;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = ST_STOP;
                end else if (w_bit_end) begin
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_bit_end && i_load) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = i_data;
                end else if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = 16'd0;
            end
        endcase

        // Line level follows the state being entered so o_tx stays registered.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

endmodule

// File: rtl/snapshot_uart_tx.sv
// Snapshot transmitter top: latches a strobed set of three 5-bit values and
// sends header + three tagged bytes back to back; strobes while busy are dropped.
module snapshot_uart_tx
    import snapshot_uart_tx_pkg::*;
#(
    parameter int         pDIV    = 16,
    parameter logic [7:0] pHEADER = HEADER_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_stb,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_drop
);

    logic [4:0] r_v100;
    logic [4:0] r_v010;
    logic [4:0] r_v001;
    logic [1:0] r_byte_idx;
    logic       r_busy;
    logic       r_drop;
    logic       w_start;
    logic       w_done;
    logic       w_chain;
    logic       w_load;
    logic [7:0] w_next_byte;
    logic [7:0] w_load_data;

    assign w_start = i_stb & ~r_busy;
    assign w_chain = r_busy & w_done & (r_byte_idx != LAST_BYTE_IDX);
    assign w_load  = w_start | w_chain;
    assign o_busy  = r_busy;
    assign o_drop  = r_drop;

    // Select the byte to hand over: header on a new frame, else the byte after r_byte_idx.
    always_comb begin
        w_next_byte = pHEADER;
        case (r_byte_idx)
            2'd0:    w_next_byte = tag_byte(TAG_100, r_v100);
            2'd1:    w_next_byte = tag_byte(TAG_010, r_v010);
            2'd2:    w_next_byte = tag_byte(TAG_001, r_v001);
            default: w_next_byte = pHEADER;
        endcase
        if (w_start) begin
            w_load_data = pHEADER;
        end else begin
            w_load_data = w_next_byte;
        end
    end

    // Snapshot latching, byte sequencing and busy/drop flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v100     <= 5'd0;
            r_v010     <= 5'd0;
            r_v001     <= 5'd0;
            r_byte_idx <= 2'd0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= i_stb & r_busy;
            if (w_start) begin
                r_v100     <= i_100;
                r_v010     <= i_010;
                r_v001     <= i_001;
                r_byte_idx <= 2'd0;
                r_busy     <= 1'b1;
            end else if (w_chain) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end else if (r_busy && w_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    uart_byte_tx #(
        .pDIV (pDIV)
    ) u_byte_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_data (w_load_data),
        .o_tx   (o_tx),
        .o_done (w_done)
    );

endmodule

// File: tb/tb_snapshot_uart_tx.sv
// Directed bench for snapshot_uart_tx: three instances (pDIV 4, 2, 25) with
// every line cycle compared against the expected 8N1 bit stream.
module tb_snapshot_uart_tx;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      stb;
    logic [2:0][4:0] v100;
    logic [2:0][4:0] v010;
    logic [2:0][4:0] v001;
    logic [2:0]      tx;
    logic [2:0]      busy;
    logic [2:0]      drop;
    int              n_checks = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    snapshot_uart_tx #(.pDIV(4)) u_div4 (
        .i_clk(clk), .i_rst(rst), .i_stb(stb[0]), .i_100(v100[0]), .i_010(v010[0]),
        .i_001(v001[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_drop(drop[0]));
    snapshot_uart_tx #(.pDIV(2)) u_div2 (
        .i_clk(clk), .i_rst(rst), .i_stb(stb[1]), .i_100(v100[1]), .i_010(v010[1]),
        .i_001(v001[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_drop(drop[1]));
    snapshot_uart_tx #(.pDIV(25)) u_div25 (
        .i_clk(clk), .i_rst(rst), .i_stb(stb[2]), .i_100(v100[2]), .i_010(v010[2]),
        .i_001(v001[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_drop(drop[2]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe one snapshot into instance k; called and returns at a negedge.
    task automatic send(input int k, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        stb[k]  = 1'b1;
        v100[k] = a;
        v010[k] = b;
        v001[k] = c;
        @(negedge clk);
        stb[k] = 1'b0;
        check_eq($sformatf("latency_tx_k%0d", k), 32'(tx[k]), 32'd0);
        check_eq($sformatf("latency_busy_k%0d", k), 32'(busy[k]), 32'd1);
    endtask

    // Walk a whole frame cycle by cycle; optionally strobe a conflicting snapshot at cycle inj.
    task automatic run_frame(input int k, input int div, input logic [31:0] exp_bytes,
                             input int inj, input int exp_drops);
        int         bad       = 0;
        int         busy_cnt  = 0;
        int         drop_cnt  = 0;
        int         cyc       = 0;
        logic [7:0] eb;
        logic [9:0] cap;
        logic       expb;
        for (int bi = 0; bi < 4; bi++) begin
            eb  = exp_bytes[31 - 8*bi -: 8];
            cap = 10'd0;
            for (int bit_i = 0; bit_i < 10; bit_i++) begin
                expb = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : eb[bit_i - 1];
                for (int cc = 0; cc < div; cc++) begin
                    if (tx[k] !== expb) bad++;
                    if (cc == div / 2) cap[bit_i] = tx[k];
                    if (busy[k]) busy_cnt++;
                    if (drop[k]) drop_cnt++;
                    if (cyc == inj) begin
                        stb[k]  = 1'b1;
                        v100[k] = 5'h01;
                        v010[k] = 5'h02;
                        v001[k] = 5'h04;
                    end else begin
                        stb[k] = 1'b0;
                    end
                    cyc++;
                    @(negedge clk);
                end
            end
            check_eq($sformatf("byte%0d_k%0d", bi, k), 32'(cap), 32'({1'b1, eb, 1'b0}));
        end
        check_eq($sformatf("bit_timing_k%0d", k), 32'(bad), 32'd0);
        check_eq($sformatf("busy_len_k%0d", k), 32'(busy_cnt), 32'(40 * div));
        check_eq($sformatf("drop_cnt_k%0d", k), 32'(drop_cnt), 32'(exp_drops));
        check_eq($sformatf("end_busy_k%0d", k), 32'(busy[k]), 32'd0);
        check_eq($sformatf("end_tx_k%0d", k), 32'(tx[k]), 32'd1);
    endtask

    initial begin
        int idle_bad;
        rst  = 1'b1;
        stb  = 3'd0;
        v100 = '0;
        v010 = '0;
        v001 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_tx_k%0d", k), 32'(tx[k]), 32'd1);
            check_eq($sformatf("rst_busy_k%0d", k), 32'(busy[k]), 32'd0);
            check_eq($sformatf("rst_drop_k%0d", k), 32'(drop[k]), 32'd0);
        end

        idle_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || drop[0] !== 1'b0) idle_bad++;
        end
        check_eq("idle_50", 32'(idle_bad), 32'd0);

        // Basic frame, then a frame disturbed by a second strobe, then a back-to-back frame.
        send(0, 5'h13, 5'h0A, 5'h1F);
        run_frame(0, 4, 32'hA5934A3F, -1, 0);
        send(0, 5'h13, 5'h0A, 5'h1F);
        run_frame(0, 4, 32'hA5934A3F, 20, 1);
        send(0, 5'h00, 5'h00, 5'h00);
        run_frame(0, 4, 32'hA5804020, -1, 0);

        // Reset in the middle of byte 2, then strobe colliding with reset.
        repeat (2) @(negedge clk);
        send(0, 5'h13, 5'h0A, 5'h1F);
        repeat (84) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_tx", 32'(tx[0]), 32'd1);
        check_eq("midrst_busy", 32'(busy[0]), 32'd0);
        rst    = 1'b1;
        stb[0] = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        stb[0] = 1'b0;
        @(negedge clk);
        check_eq("rst_stb_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_stb_tx", 32'(tx[0]), 32'd1);
        send(0, 5'h13, 5'h0A, 5'h1F);
        run_frame(0, 4, 32'hA5934A3F, -1, 0);

        // Extreme dividers with all-zero and all-one values.
        send(1, 5'h00, 5'h00, 5'h00);
        run_frame(1, 2, 32'hA5804020, -1, 0);
        send(1, 5'h1F, 5'h1F, 5'h1F);
        run_frame(1, 2, 32'hA59F5F3F, -1, 0);
        send(2, 5'h00, 5'h00, 5'h00);
        run_frame(2, 25, 32'hA5804020, -1, 0);
        send(2, 5'h1F, 5'h1F, 5'h1F);
        run_frame(2, 25, 32'hA59F5F3F, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snapshot_uart_tx.md
# snapshot_uart_tx

Serial transmitter for the capture snapshots: accepts one strobe-qualified set of three 5-bit sampled values and sends it off-chip as a fixed 4-byte UART frame (8N1, LSB first) on a single output pin. Sits downstream of the periodic capture stage and is the only path by which the sampled counter states leave the design. New snapshots arriving while a frame is in flight are dropped and flagged.

## Interface

- pDIV, 16, clock cycles per UART bit; legal range 2..65535
- pHEADER, 8'hA5, first byte of every frame

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_stb  in  1  single-cycle strobe: i_100/i_010/i_001 hold a new snapshot
- i_100  in  5  snapshot value, channel 100
- i_010  in  5  snapshot value, channel 010
- i_001  in  5  snapshot value, channel 001
- o_tx   out 1  UART serial output, idle high
- o_busy out 1  frame in progress; i_stb is ignored while high
- o_drop out 1  one-cycle pulse: i_stb arrived while o_busy high

## Operation

- Reset values: o_tx=1, o_busy=0, o_drop=0, state IDLE, holding registers 0.
- i_stb sampled high with o_busy=0: latch i_100, i_010, i_001 into holding registers; start frame.
- i_stb sampled high with o_busy=1: inputs ignored, current frame undisturbed, o_drop=1 for exactly one cycle.
- Frame bytes, in order: B0=pHEADER, B1={3'b100,v100}, B2={3'b010,v010}, B3={3'b001,v001}.
- Each byte: start bit 0, data bits d0..d7 (LSB first), stop bit 1; each bit held pDIV cycles.
- No idle gap between bytes: stop bit of Bn is immediately followed by start bit of Bn+1.
- States: IDLE -> START -> DATA (8 bits) -> STOP -> START (byte index 0..2 -> index+1) or IDLE (index 3).
- Byte index 2 bits, bit index 3 bits, bit timer 16 bits; timer counts 0..pDIV-1, advancing the bit on pDIV-1.
- Reset mid-frame: abandon frame; o_tx=1 and o_busy=0 from the cycle after i_rst is sampled.
- i_stb together with i_rst: reset wins, snapshot not latched.

## Timing

- Latency: i_stb sampled at edge N -> o_tx=0 (start of B0) and o_busy=1 from edge N+1.
- Frame length: 40*pDIV cycles; o_busy high for exactly 40*pDIV cycles, low from the cycle after B3's stop bit ends.
- i_stb sampled in the first cycle with o_busy=0 after a frame is accepted (back-to-back frames, no gap).
- i_stb in the last stop-bit cycle (o_busy still 1) is dropped with o_drop pulse.
- o_tx, o_busy, o_drop all registered; no combinational input-to-output paths.
- With capture period 1001 cycles, pDIV must be at most 25 so every snapshot is sent; larger pDIV produces drops by design.

## Structure

- Shared package: state enum (IDLE, START, DATA, STOP), channel tag constants 3'b100/3'b010/3'b001, default header 8'hA5, frame byte count 4.
- Sub-module uart_byte_tx: one 8N1 byte with load/ready handshake and pDIV bit timer; top level owns snapshot latching, byte sequencing, busy/drop logic.

## Test plan

- pDIV=4, reset then idle 50 cycles -> o_tx=1, o_busy=0, o_drop=0 throughout.
- pDIV=4, i_stb with 100=5'h13, 010=5'h0A, 001=5'h1F -> o_tx low the next cycle; decoded bytes A5, 93, 4A, 3F; o_busy high exactly 160 cycles.
- Second i_stb 20 cycles into a frame with different values -> o_drop single-cycle pulse; frame bytes unchanged.
- i_stb on the first cycle o_busy=0 after a frame -> new frame starts next cycle, no extra idle bit.
- i_rst asserted mid-byte B2 -> o_tx=1, o_busy=0 next cycle; subsequent i_stb produces a complete, correct frame.
- pDIV=2 and pDIV=25 with values 0 and 5'h1F -> every bit exactly pDIV cycles wide; bytes A5, 80/9F, 40/5F, 20/3F.
